// File: rtl/pin_entry_controller.sv
// PIN entry front-end for the ATM authenticator: card latch, 4-digit BCD PIN, attempt count, lockout.
// Optional feature: define DIGIT_BACKSPACE_EN to enable the 0xD backspace key.
module pin_entry_controller #(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int LOCK_CYCLES    = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        card_present,
  input  logic [3:0]  card_acc_num,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        acc_found_stat,
  input  logic        acc_auth_stat,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic        auth_req,
  output logic        session_ok,
  output logic        session_fail,
  output logic        locked,
  output logic [1:0]  attempts_left,
  output logic [2:0]  digit_count
);

  localparam int TMAX = (TIMEOUT_CYCLES > LOCK_CYCLES) ? TIMEOUT_CYCLES : LOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST     = TW'(LOCK_CYCLES - 1);
  localparam logic [1:0]    ATTEMPTS_INIT = 2'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {IDLE, ENTER, CHECK, GRANTED, LOCKED} state_t;

  state_t        state_q, state_d;
  logic          card_q;
  logic          card_rise;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    acc_d;
  logic [15:0]   pin_d;
  logic [2:0]    dc_d;
  logic [1:0]    att_d;
  logic          auth_req_d;
  logic          fail_d;
  logic          key_hit;

  // card_q tracks the card level in every state, so a card held through LOCKED needs re-insertion
  assign card_rise = card_present & ~card_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    acc_d      = acc_num;
    pin_d      = pin;
    dc_d       = digit_count;
    att_d      = attempts_left;
    auth_req_d = 1'b0;
    fail_d     = 1'b0;
    key_hit    = 1'b0;

    case (state_q)
      IDLE: begin
        if (card_rise) begin
          acc_d   = card_acc_num;
          att_d   = ATTEMPTS_INIT;
          state_d = ENTER;
        end
      end

      ENTER: begin
        if (!card_present) begin
          state_d = IDLE;
        end else begin
          if (key_valid) begin
            if (key_code <= 4'd9) begin
              if (digit_count < 3'd4) begin
                pin_d   = {pin[11:0], key_code};
                dc_d    = digit_count + 3'd1;
                key_hit = 1'b1;
              end
            end else begin
              case (key_code)
                4'hC: begin
                  pin_d   = '0;
                  dc_d    = '0;
                  key_hit = 1'b1;
                end
                4'hE: begin
                  if (digit_count == 3'd4) begin
                    auth_req_d = 1'b1;
                    state_d    = CHECK;
                    key_hit    = 1'b1;
                  end
                end
                4'hF: begin
                  state_d = IDLE;
                  key_hit = 1'b1;
                end
`ifdef DIGIT_BACKSPACE_EN
                4'hD: begin
                  if (digit_count != 3'd0) begin
                    pin_d   = {4'h0, pin[15:4]};
                    dc_d    = digit_count - 3'd1;
                    key_hit = 1'b1;
                  end
                end
`else
`endif
                default: ;
              endcase
            end
          end
          // only accepted keys restart the idle window
          if (key_hit) begin
            timer_d = '0;
          end else if (timer_q == TIMEOUT_LAST) begin
            fail_d  = 1'b1;
            state_d = IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end

      CHECK: begin
        if (!card_present) begin
          state_d = IDLE;
        end else if (!acc_found_stat) begin
          fail_d  = 1'b1;
          state_d = IDLE;
        end else if (acc_auth_stat) begin
          state_d = GRANTED;
        end else if (attempts_left > 2'd1) begin
          att_d   = attempts_left - 2'd1;
          pin_d   = '0;
          dc_d    = '0;
          state_d = ENTER;
        end else begin
          att_d   = '0;
          fail_d  = 1'b1;
          state_d = LOCKED;
        end
      end

      GRANTED: begin
        if (!card_present) state_d = IDLE;
      end

      LOCKED: begin
        if (timer_q == LOCK_LAST) state_d = IDLE;
        else timer_d = timer_q + 1'b1;
      end

      default: state_d = IDLE;
    endcase

    // every state change restarts the shared timer; IDLE entry wipes the PIN
    if (state_d != state_q) timer_d = '0;
    if (state_d == IDLE) begin
      pin_d = '0;
      dc_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      card_q        <= 1'b0;
      timer_q       <= '0;
      acc_num       <= '0;
      pin           <= '0;
      digit_count   <= '0;
      attempts_left <= ATTEMPTS_INIT;
      auth_req      <= 1'b0;
      session_fail  <= 1'b0;
      session_ok    <= 1'b0;
      locked        <= 1'b0;
    end else begin
      state_q       <= state_d;
      card_q        <= card_present;
      timer_q       <= timer_d;
      acc_num       <= acc_d;
      pin           <= pin_d;
      digit_count   <= dc_d;
      attempts_left <= att_d;
      auth_req      <= auth_req_d;
      session_fail  <= fail_d;
      session_ok    <= (state_d == GRANTED);
      locked        <= (state_d == LOCKED);
    end
  end

endmodule

// File: tb/tb_pin_entry_controller.sv
// Directed bench for pin_entry_controller with short timeout/lock windows.
// Expected PIN in the backspace test follows DIGIT_BACKSPACE_EN.
module tb_pin_entry_controller;

  localparam int TO = 20;
  localparam int LK = 30;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        card_present;
  logic [3:0]  card_acc_num;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        acc_found_stat;
  logic        acc_auth_stat;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic        auth_req;
  logic        session_ok;
  logic        session_fail;
  logic        locked;
  logic [1:0]  attempts_left;
  logic [2:0]  digit_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pin_entry_controller #(
    .MAX_ATTEMPTS(3),
    .TIMEOUT_CYCLES(TO),
    .LOCK_CYCLES(LK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .card_present(card_present),
    .card_acc_num(card_acc_num),
    .key_valid(key_valid),
    .key_code(key_code),
    .acc_found_stat(acc_found_stat),
    .acc_auth_stat(acc_auth_stat),
    .acc_num(acc_num),
    .pin(pin),
    .auth_req(auth_req),
    .session_ok(session_ok),
    .session_fail(session_fail),
    .locked(locked),
    .attempts_left(attempts_left),
    .digit_count(digit_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // inputs change 1 time unit after the edge; outputs are sampled at the same point
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic stepCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic applyStimulus(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    stepCycle();
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic insertCard(input logic [3:0] acc);
    card_present = 1'b1;
    card_acc_num = acc;
    stepCycle();
  endtask

  task automatic removeCard();
    card_present = 1'b0;
    stepCycle();
  endtask

  initial begin
    logic [15:0] bs_pin;
    rst_n          = 1'b0;
    card_present   = 1'b0;
    card_acc_num   = 4'h0;
    key_valid      = 1'b0;
    key_code       = 4'h0;
    acc_found_stat = 1'b1;
    acc_auth_stat  = 1'b1;
    #12;
    checkOutput("rst_pin", {16'h0, pin}, 32'h0);
    checkOutput("rst_acc", {28'h0, acc_num}, 32'h0);
    checkOutput("rst_att", {30'h0, attempts_left}, 32'd3);
    checkOutput("rst_dc", {29'h0, digit_count}, 32'd0);
    checkOutput("rst_flags", {27'h0, auth_req, session_ok, session_fail, locked, 1'b0}, 32'h0);
    rst_n = 1'b1;
    stepCycle();

    // T1: correct PIN, grant, removal
    insertCard(4'd3);
    checkOutput("t1_acc", {28'h0, acc_num}, 32'd3);
    applyStimulus(4'd1); applyStimulus(4'd2); applyStimulus(4'd3); applyStimulus(4'd4);
    checkOutput("t1_pin", {16'h0, pin}, 32'h1234);
    checkOutput("t1_dc", {29'h0, digit_count}, 32'd4);
    applyStimulus(4'hE);
    checkOutput("t1_auth_req", {31'h0, auth_req}, 32'd1);
    stepCycle();
    checkOutput("t1_auth_req_pulse", {31'h0, auth_req}, 32'd0);
    checkOutput("t1_ok", {31'h0, session_ok}, 32'd1);
    stepCycles(3);
    checkOutput("t1_ok_hold", {31'h0, session_ok}, 32'd1);
    removeCard();
    checkOutput("t1_ok_drop", {31'h0, session_ok}, 32'd0);
    checkOutput("t1_pin_clr", {16'h0, pin}, 32'h0);
    checkOutput("t1_acc_hold", {28'h0, acc_num}, 32'd3);

    // T2: three wrong PINs lead to lockout
    acc_found_stat = 1'b1;
    acc_auth_stat  = 1'b0;
    insertCard(4'd5);
    for (int a = 0; a < 3; a++) begin
      for (int d = 0; d < 4; d++) applyStimulus(4'd1);
      applyStimulus(4'hE);
      stepCycle();
      checkOutput($sformatf("t2_att%0d", a), {30'h0, attempts_left}, 32'(2 - a));
      checkOutput($sformatf("t2_fail%0d", a), {31'h0, session_fail}, (a == 2) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t2_lock%0d", a), {31'h0, locked}, (a == 2) ? 32'd1 : 32'd0);
      if (a < 2) checkOutput($sformatf("t2_pinclr%0d", a), {16'h0, pin}, 32'h0);
    end
    applyStimulus(4'd7);
    checkOutput("t2_fail_pulse", {31'h0, session_fail}, 32'd0);
    checkOutput("t2_key_ignored", {16'h0, pin}, 32'h1111);
    stepCycles(LK - 2);
    checkOutput("t2_lock_last", {31'h0, locked}, 32'd1);
    stepCycle();
    checkOutput("t2_lock_exit", {31'h0, locked}, 32'd0);
    checkOutput("t2_exit_pin", {16'h0, pin}, 32'h0);
    stepCycles(3);
    checkOutput("t2_no_restart", {30'h0, attempts_left}, 32'd0);
    removeCard();

    // T3: unknown account
    acc_found_stat = 1'b0;
    insertCard(4'd7);
    applyStimulus(4'd9); applyStimulus(4'd8); applyStimulus(4'd7); applyStimulus(4'd6);
    applyStimulus(4'hE);
    stepCycle();
    checkOutput("t3_fail", {31'h0, session_fail}, 32'd1);
    checkOutput("t3_att", {30'h0, attempts_left}, 32'd3);
    applyStimulus(4'd1);
    checkOutput("t3_fail_pulse", {31'h0, session_fail}, 32'd0);
    checkOutput("t3_idle_dc", {29'h0, digit_count}, 32'd0);
    removeCard();

    // T4: short PIN enter ignored, 5th digit dropped, clear
    acc_found_stat = 1'b1;
    insertCard(4'd2);
    applyStimulus(4'd5); applyStimulus(4'd6); applyStimulus(4'hE);
    checkOutput("t4_no_auth", {31'h0, auth_req}, 32'd0);
    checkOutput("t4_dc2", {29'h0, digit_count}, 32'd2);
    applyStimulus(4'd7); applyStimulus(4'd8); applyStimulus(4'd9);
    checkOutput("t4_pin", {16'h0, pin}, 32'h5678);
    checkOutput("t4_dc4", {29'h0, digit_count}, 32'd4);
    applyStimulus(4'hC);
    checkOutput("t4_clr_pin", {16'h0, pin}, 32'h0);
    checkOutput("t4_clr_dc", {29'h0, digit_count}, 32'd0);
    removeCard();

    // T5: timeout, and card pull racing the enter key
    insertCard(4'd4);
    stepCycles(TO - 1);
    checkOutput("t5_pre_timeout", {31'h0, session_fail}, 32'd0);
    stepCycle();
    checkOutput("t5_timeout", {31'h0, session_fail}, 32'd1);
    stepCycle();
    checkOutput("t5_timeout_pulse", {31'h0, session_fail}, 32'd0);
    removeCard();
    insertCard(4'd6);
    applyStimulus(4'd1); applyStimulus(4'd2); applyStimulus(4'd3); applyStimulus(4'd4);
    card_present = 1'b0;
    applyStimulus(4'hE);
    checkOutput("t5_pull_auth", {31'h0, auth_req}, 32'd0);
    checkOutput("t5_pull_fail", {31'h0, session_fail}, 32'd0);
    checkOutput("t5_pull_pin", {16'h0, pin}, 32'h0);
    stepCycle();

    // T6: backspace
    insertCard(4'd1);
    applyStimulus(4'd1); applyStimulus(4'd2); applyStimulus(4'hD);
    applyStimulus(4'd3); applyStimulus(4'd4); applyStimulus(4'd5);
`ifdef DIGIT_BACKSPACE_EN
    bs_pin = 16'h1345;
`else
    bs_pin = 16'h1234;
`endif
    checkOutput("t6_pin", {16'h0, pin}, {16'h0, bs_pin});
    checkOutput("t6_dc", {29'h0, digit_count}, 32'd4);

    // async reset mid-session
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_pin", {16'h0, pin}, 32'h0);
    checkOutput("rst_mid_acc", {28'h0, acc_num}, 32'h0);
    checkOutput("rst_mid_dc", {29'h0, digit_count}, 32'd0);
    rst_n = 1'b1;
    stepCycles(2);
    checkOutput("rst_mid_fail", {31'h0, session_fail}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
